// File: rtl/control_decode_pkg.sv
// Shared opcode constants, FSM state encoding and ALU operation select for the
// control decoder and its testbench.
package control_decode_pkg;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    EXEC     = 2'd1,
    FETCH_LO = 2'd2,
    JUMP     = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_NAND = 2'd1,
    ALU_CMP  = 2'd2
  } alu_op_e;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LIT   = 4'h1;
  localparam logic [3:0] OP_ADDI  = 4'h2;
  localparam logic [3:0] OP_NANDI = 4'h3;
  localparam logic [3:0] OP_IN    = 4'h4;
  localparam logic [3:0] OP_OUT   = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_JC    = 4'h7;
  localparam logic [3:0] OP_JNC   = 4'h8;
  localparam logic [3:0] OP_JZ    = 4'h9;
  localparam logic [3:0] OP_JNZ   = 4'hA;
  localparam logic [3:0] OP_CMPI  = 4'hB;

  function automatic logic isJump(input logic [3:0] op);
    return (op >= OP_JMP) && (op <= OP_JNZ);
  endfunction

endpackage

// File: rtl/control_decode_alu4.sv
// 4-bit add / nand / compare unit; compare computes a + ~b + 1 so carry means
// "no borrow".
module alu4
  import control_decode_pkg::*;
(
  input  alu_op_e    op_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [3:0] result_o,
  output logic       carry_o,
  output logic       zero_o
);

  logic [4:0] sum;

  always_comb begin
    sum = 5'd0;
    case (op_i)
      ALU_ADD:  sum = {1'b0, a_i} + {1'b0, b_i};
      ALU_NAND: sum = {1'b0, ~(a_i & b_i)};
      ALU_CMP:  sum = {1'b0, a_i} + {1'b0, ~b_i} + 5'd1;
      default:  sum = {1'b0, a_i};
    endcase
  end

  assign result_o = sum[3:0];
  assign carry_o  = sum[4];
  assign zero_o   = (sum[3:0] == 4'd0);

endmodule

// File: rtl/control_decode.sv
// Four-state instruction sequencer and datapath registers for the 4-bit core;
// drives the fetch unit's enable/load strobes and executes one opcode per EXEC.
module control_decode
  import control_decode_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  instr,
  input  logic [3:0]  operand,
  input  logic [3:0]  data_in,
  output logic        enF,
  output logic        enP,
  output logic        load,
  output logic [11:0] load_1,
  output logic [3:0]  acc,
  output logic        c_flag,
  output logic        z_flag,
  output logic [3:0]  data_out,
  output logic        out_strobe
);

  state_e     state_q, state_d;
  logic [3:0] acc_q, acc_d;
  logic       c_q, c_d;
  logic       z_q, z_d;
  logic [3:0] dout_q, dout_d;
  logic       strobe_q, strobe_d;
  logic [3:0] hi_q, hi_d;
  logic [3:0] jop_q, jop_d;

  alu_op_e    aluOp;
  logic [3:0] aluRes;
  logic       aluC, aluZ;
  logic       taken;

  alu4 u_alu (
    .op_i     (aluOp),
    .a_i      (acc_q),
    .b_i      (operand),
    .result_o (aluRes),
    .carry_o  (aluC),
    .zero_o   (aluZ)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= FETCH;
      acc_q    <= 4'd0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      dout_q   <= 4'd0;
      strobe_q <= 1'b0;
      hi_q     <= 4'd0;
      jop_q    <= OP_NOP;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      c_q      <= c_d;
      z_q      <= z_d;
      dout_q   <= dout_d;
      strobe_q <= strobe_d;
      hi_q     <= hi_d;
      jop_q    <= jop_d;
    end
  end

  always_comb begin
    case (instr)
      OP_NANDI: aluOp = ALU_NAND;
      OP_CMPI:  aluOp = ALU_CMP;
      default:  aluOp = ALU_ADD;
    endcase
  end

  // The jump opcode is remembered from EXEC because instr holds the low target byte by JUMP.
  always_comb begin
    case (jop_q)
      OP_JMP:  taken = 1'b1;
      OP_JC:   taken = c_q;
      OP_JNC:  taken = ~c_q;
      OP_JZ:   taken = z_q;
      OP_JNZ:  taken = ~z_q;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    c_d      = c_q;
    z_d      = z_q;
    dout_d   = dout_q;
    strobe_d = 1'b0;
    hi_d     = hi_q;
    jop_d    = jop_q;
    enF      = 1'b0;
    enP      = 1'b0;
    load     = 1'b0;
    load_1   = 12'd0;

    case (state_q)
      FETCH: begin
        enF     = 1'b1;
        enP     = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        state_d = FETCH;
        case (instr)
          OP_LIT: acc_d = operand;
          OP_ADDI: begin
            acc_d = aluRes;
            c_d   = aluC;
            z_d   = aluZ;
          end
          OP_NANDI: begin
            acc_d = aluRes;
            z_d   = aluZ;
          end
          OP_IN: begin
            acc_d = data_in;
            z_d   = (data_in == 4'd0);
          end
          OP_OUT: begin
            dout_d   = acc_q;
            strobe_d = 1'b1;
          end
          OP_CMPI: begin
            c_d = aluC;
            z_d = aluZ;
          end
          default: begin
            if (isJump(instr)) begin
              hi_d    = operand;
              jop_d   = instr;
              state_d = FETCH_LO;
            end
          end
        endcase
      end
      FETCH_LO: begin
        enF     = 1'b1;
        enP     = 1'b1;
        state_d = JUMP;
      end
      JUMP: begin
        state_d = FETCH;
        if (taken) begin
          load   = 1'b1;
          enP    = 1'b1;
          load_1 = {hi_q, instr, operand};
        end
      end
      default: state_d = FETCH;
    endcase

    // Reset must suppress every fetch-unit strobe on the very edge it is sampled.
    if (reset) begin
      enF    = 1'b0;
      enP    = 1'b0;
      load   = 1'b0;
      load_1 = 12'd0;
    end
  end

  assign acc        = acc_q;
  assign c_flag     = c_q;
  assign z_flag     = z_q;
  assign data_out   = dout_q;
  assign out_strobe = strobe_q;

endmodule
